// File: rtl/dot_product_pkg.sv
// Shared types and helpers for dot_product_array: FSM encoding, accumulator
// sizing and the round-half-up / saturate step applied to each row sum.
package dot_product_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_ROUND  = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  // Rounding is done on a wide signed container so one function serves every
  // parameterisation; accumulator widths must stay below WIDE_W.
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int acc_width(input int data_width, input int max_len);
    return 2 * data_width + $clog2(max_len);
  endfunction

  function automatic wide_t round_sat(input wide_t acc, input int frac_bits,
                                      input int data_width);
    wide_t rnd;
    wide_t y;
    wide_t max_v;
    wide_t min_v;
    rnd   = (frac_bits > 0) ? (wide_t'(1) <<< (frac_bits - 1)) : '0;
    y     = (acc + rnd) >>> frac_bits;
    max_v = (wide_t'(1) <<< (data_width - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (data_width - 1));
    if (y > max_v) return max_v;
    if (y < min_v) return min_v;
    return y;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane: clear loads init_i, enable adds a*b.
module mac_lane #(
  parameter int DW    = 16,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr_i,
  input  logic signed [ACC_W-1:0] init_i,
  input  logic                    en_i,
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod = (2*DW)'(a_i) * (2*DW)'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = init_i;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dot_product_array.sv
// NUM_ROWS parallel signed fixed-point dot products against one vector x,
// streamed out row by row. Optional per-row bias: DOT_PRODUCT_ARRAY_BIAS_EN.
module dot_product_array
  import dot_product_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int FRAC_BITS  = 8,
  parameter  int MAX_LEN    = 16,
  parameter  int NUM_ROWS   = 4,
  localparam int ADDR_W     = $clog2(MAX_LEN),
  localparam int ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [ROW_W-1:0]      write_row,
  input  logic                  write_en_w,
  input  logic                  write_en_x,
`ifdef DOT_PRODUCT_ARRAY_BIAS_EN
  input  logic                  write_en_b,
`endif
  input  logic                  start_calc,
  input  logic [LEN_W-1:0]      vector_length,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ROW_W-1:0]      result_row,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  calc_done,
  output state_e                dbg_state_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_LEN);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       k_q, k_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    done_q, done_d;
  logic                    acc_clr, mac_en, buf_load;
  logic [LEN_W-1:0]        len_clamp;
  logic                    last_k, last_row, accept;

  logic [DATA_WIDTH-1:0]   w_mem [NUM_ROWS][MAX_LEN];
  logic [DATA_WIDTH-1:0]   x_mem [MAX_LEN];
  logic signed [ACC_W-1:0] acc      [NUM_ROWS];
  logic signed [ACC_W-1:0] init_val [NUM_ROWS];
  logic [DATA_WIDTH-1:0]   res_q    [NUM_ROWS];

  // valid/ready: a beat transfers on a rising edge where result_valid and
  // result_ready are both high; result/result_row hold until that edge.
  assign len_clamp = (vector_length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vector_length;
  assign last_k    = (LEN_W'(k_q) + LEN_W'(1)) == len_q;
  assign last_row  = row_q == ROW_W'(NUM_ROWS - 1);
  assign accept    = result_valid && result_ready;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    row_d    = row_q;
    done_d   = 1'b0;
    acc_clr  = 1'b0;
    mac_en   = 1'b0;
    buf_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_calc) begin
          len_d   = len_clamp;
          k_d     = '0;
          row_d   = '0;
          acc_clr = 1'b1;
          state_d = (len_clamp == '0) ? S_ROUND : S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + ADDR_W'(1);
        if (last_k) state_d = S_ROUND;
      end
      S_ROUND: begin
        buf_load = 1'b1;
        row_d    = '0;
        state_d  = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (accept) begin
          if (last_row) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NUM_ROWS; r++) res_q[r] <= '0;
    end else if (buf_load) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        res_q[r] <= DATA_WIDTH'(round_sat(wide_t'(acc[r]), FRAC_BITS, DATA_WIDTH));
      end
    end
  end

  // Operand RAMs have no reset and are frozen while a calculation runs.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      if (write_en_w) w_mem[write_row][write_addr] <= data_in;
      if (write_en_x) x_mem[write_addr] <= data_in;
    end
  end

`ifdef DOT_PRODUCT_ARRAY_BIAS_EN
  logic [DATA_WIDTH-1:0] b_mem [NUM_ROWS];

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && write_en_b) b_mem[write_row] <= data_in;
  end
`endif

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
`ifdef DOT_PRODUCT_ARRAY_BIAS_EN
    assign init_val[r] = ACC_W'(signed'(b_mem[r])) <<< FRAC_BITS;
`else
    assign init_val[r] = '0;
`endif
    mac_lane #(
      .DW   (DATA_WIDTH),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .clr_i (acc_clr),
      .init_i(init_val[r]),
      .en_i  (mac_en),
      .a_i   (w_mem[r][k_q]),
      .b_i   (x_mem[k_q]),
      .acc_o (acc[r])
    );
  end

  assign busy         = state_q != S_IDLE;
  assign result_valid = state_q == S_OUTPUT;
  assign result_row   = row_q;
  assign result       = res_q[row_q];
  assign calc_done    = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dot_product_array.sv
// Randomised bench for dot_product_array against a plain-arithmetic model of
// the row dot products, rounding and saturation.
module tb_dot_product_array;
  import dot_product_pkg::*;

  localparam int DW      = 16;
  localparam int FRAC    = 8;
  localparam int MAX_LEN = 16;
  localparam int NR      = 4;
  localparam int ADDR_W  = 4;
  localparam int ROW_W   = 2;
  localparam int LEN_W   = 5;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rstn;
  logic [DW-1:0]     data_in;
  logic [ADDR_W-1:0] write_addr;
  logic [ROW_W-1:0]  write_row;
  logic              write_en_w, write_en_x;
  logic              start_calc;
  logic [LEN_W-1:0]  vector_length;
  logic              busy, result_valid, result_ready, calc_done;
  logic [ROW_W-1:0]  result_row;
  logic [DW-1:0]     result;
  state_e            dbg_state;

  always #5 clk = ~clk;

  dot_product_array dut (
    .clk          (clk),
    .rstn         (rstn),
    .data_in      (data_in),
    .write_addr   (write_addr),
    .write_row    (write_row),
    .write_en_w   (write_en_w),
    .write_en_x   (write_en_x),
`ifdef DOT_PRODUCT_ARRAY_BIAS_EN
    .write_en_b   (1'b0),
`endif
    .start_calc   (start_calc),
    .vector_length(vector_length),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_row   (result_row),
    .result       (result),
    .calc_done    (calc_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- model / scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0]        exp_q[$];
  logic signed [DW-1:0] w_m [NR][MAX_LEN];
  logic signed [DW-1:0] x_m [MAX_LEN];

  function automatic logic [DW-1:0] model_row(input int r, input int len);
    longint acc;
    longint y;
    int     eff;
    acc = 0;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    for (int k = 0; k < eff; k++) acc += longint'(w_m[r][k]) * longint'(x_m[k]);
    y = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return DW'(y);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    int v;
    case ($urandom_range(0, 3))
      0:       return DW'($urandom);
      1:       v = int'($urandom_range(0, 511)) - 256;
      default: v = int'($urandom_range(0, 4095)) - 2048;
    endcase
    return DW'(v);
  endfunction

  task automatic fill_random();
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < MAX_LEN; k++) w_m[r][k] = rand_word();
    for (int k = 0; k < MAX_LEN; k++) x_m[k] = rand_word();
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_all();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        write_en_w = 1'b1;
        write_row  = ROW_W'(r);
        write_addr = ADDR_W'(k);
        data_in    = w_m[r][k];
        @(posedge clk); #1;
      end
    end
    write_en_w = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      write_en_x = 1'b1;
      write_addr = ADDR_W'(k);
      data_in    = x_m[k];
      @(posedge clk); #1;
    end
    write_en_x = 1'b0;
  endtask

  task automatic drive_start(input int len);
    vector_length = LEN_W'(len);
    start_calc    = 1'b1;
    @(posedge clk); #1;
    start_calc    = 1'b0;
  endtask

  // Runs one calculation from the cycle after the start edge until calc_done.
  // rmode: 0 ready always high, 1 ready toggling 1010, 2 random ready.
  task automatic collect(input int len, input int rmode, input bit poke, input int chain_len);
    int eff, cyc, beats, done_cnt, exp_row, last_acc;
    bit seen_valid, stalled, phase, rdy, chained;
    logic [DW-1:0]    held_res, exp_v;
    logic [ROW_W-1:0] held_row;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    exp_q.delete();
    for (int r = 0; r < NR; r++) exp_q.push_back(model_row(r, len));
    cyc = 1; beats = 0; done_cnt = 0; exp_row = 0; last_acc = -100;
    seen_valid = 0; stalled = 0; phase = 0; chained = 0;
    held_res = '0; held_row = '0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_rise: busy=%b, want 1", busy);
    end
    while (cyc < 400 && !(done_cnt > 0 && cyc > last_acc + ((chain_len >= 0) ? 1 : 2))) begin
      if (poke && cyc == 2) begin
        write_en_w = 1'b1; write_en_x = 1'b1; write_row = '0; write_addr = '0;
        data_in = ~w_m[0][0]; start_calc = 1'b1; vector_length = LEN_W'(1);
      end else if (poke && cyc == 3) begin
        write_en_w = 1'b0; write_en_x = 1'b0; start_calc = 1'b0;
      end
      if (calc_done === 1'b1) begin
        done_cnt++;
        vectors++;
        if (cyc != last_acc + 1 || beats != NR) begin
          miscompares++;
          $display("FAIL done_timing: calc_done at cycle %0d after %0d beats, want cycle %0d after %0d",
                   cyc, beats, last_acc + 1, NR);
        end
        if (chain_len >= 0 && !chained) begin
          start_calc = 1'b1; vector_length = LEN_W'(chain_len); chained = 1;
        end
      end
      if (stalled) begin
        vectors++;
        if (result_valid !== 1'b1 || result !== held_res || result_row !== held_row) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b result=%h row=%0d, want 1 %h %0d",
                   result_valid, result, result_row, held_res, held_row);
        end
      end
      if (result_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1;
        vectors++;
        if (cyc != eff + 2) begin
          miscompares++;
          $display("FAIL latency: first valid at cycle %0d, want %0d", cyc, eff + 2);
        end
      end
      case (rmode)
        0: rdy = 1'b1;
        1: begin
          if (result_valid === 1'b1) begin rdy = !phase; phase = !phase; end
          else rdy = 1'b1;
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      result_ready = rdy;
      if (result_valid === 1'b1 && rdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: row=%0d result=%h, want no beat", result_row, result);
        end else begin
          exp_v = exp_q.pop_front();
          if (result !== exp_v || result_row !== ROW_W'(exp_row)) begin
            miscompares++;
            $display("FAIL beat: result=%h row=%0d, want %h row %0d (L=%0d)",
                     result, result_row, exp_v, exp_row, len);
          end
        end
        exp_row++; beats++; last_acc = cyc;
      end
      stalled  = (result_valid === 1'b1) && !rdy;
      held_res = result;
      held_row = result_row;
      @(posedge clk); #1;
      cyc++;
      if (chained) start_calc = 1'b0;
    end
    result_ready = 1'b0;
    vectors++;
    if (cyc >= 400) begin
      miscompares++;
      $display("FAIL timeout: %0d beats, %0d calc_done pulses after %0d cycles", beats, done_cnt, cyc);
    end
    vectors++;
    if (beats != NR || done_cnt != 1) begin
      miscompares++;
      $display("FAIL beat_count: beats=%0d done_pulses=%0d, want %0d and 1", beats, done_cnt, NR);
    end
    vectors++;
    if (busy !== ((chain_len >= 0) ? 1'b1 : 1'b0)) begin
      miscompares++;
      $display("FAIL busy_end: busy=%b, want %b", busy, (chain_len >= 0));
    end
  endtask

  task automatic run_calc(input int len, input int rmode, input bit poke);
    drive_start(len);
    collect(len, rmode, poke, -1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result_row !== '0 || result !== '0 ||
        calc_done !== 1'b0 || dbg_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL reset: busy=%b valid=%b row=%0d result=%h done=%b, want all 0",
               busy, result_valid, result_row, result, calc_done);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fill_random();
    w_m[0][0] = 16'h0100; w_m[0][1] = 16'h0200; w_m[0][2] = 16'h0300;
    for (int k = 0; k < 3; k++) x_m[k] = 16'h0100;
    load_all();
    run_calc(3, 0, 0);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < MAX_LEN; k++) w_m[r][k] = 16'h7F00;
    for (int k = 0; k < MAX_LEN; k++) x_m[k] = 16'h7F00;
    load_all();
    run_calc(4, 0, 0);
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < MAX_LEN; k++) w_m[r][k] = 16'h8100;
    load_all();
    run_calc(4, 0, 0);
  endtask

  task automatic test_rounding();
    logic [DW-1:0] xs [4];
    xs[0] = 16'h0080; xs[1] = 16'h007F; xs[2] = 16'hFF80; xs[3] = 16'hFF7F;
    fill_random();
    for (int r = 0; r < NR; r++) w_m[r][0] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      x_m[0] = xs[i];
      load_all();
      run_calc(1, 0, 0);
    end
  endtask

  task automatic test_len_edge();
    fill_random();
    load_all();
    run_calc(0, 0, 0);
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < MAX_LEN; k++) w_m[r][k] = 16'h0100;
    for (int k = 0; k < MAX_LEN; k++) x_m[k] = 16'h0100;
    load_all();
    run_calc(20, 0, 0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    load_all();
    drive_start(3);
    collect(3, 0, 0, 7);
    collect(7, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    fill_random();
    load_all();
    run_calc(6, 1, 0);
  endtask

  task automatic test_busy_ignore();
    fill_random();
    load_all();
    run_calc(5, 0, 1);
    run_calc(5, 0, 0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    fill_random();
    load_all();
    drive_start(16);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || calc_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b valid=%b done=%b, want 0 0 0", busy, result_valid, calc_done);
    end
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (calc_done !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_quiet: activity after mid-run reset, want none");
    end
    run_calc(16, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      fill_random();
      load_all();
      run_calc(int'($urandom_range(0, 20)), 2, 0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rstn = 1'b0; data_in = '0; write_addr = '0; write_row = '0;
    write_en_w = 1'b0; write_en_x = 1'b0; start_calc = 1'b0;
    vector_length = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_len_edge();
    test_back_to_back();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dot_product_array.md
# dot_product_array

Parametrised successor to the single-vector dot-product top for the GRU equalizer datapath. It holds one input vector x and a NUM_ROWS × MAX_LEN weight matrix. On `start_calc` it computes NUM_ROWS signed fixed-point dot products in parallel, one MAC per row per cycle. It then rounds and saturates each sum and streams the row results out over a valid/ready handshake. It sits between the serial loader and the gate-activation stage.

## Interface
- DATA_WIDTH, 16: signed fixed-point word width of weights, x and results.
- FRAC_BITS, 8: fractional bits of every operand and of the result (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- MAX_LEN, 16: maximum vector length (≥2).
- NUM_ROWS, 4: parallel rows / MAC lanes (≥1).
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- data_in  in  DATA_WIDTH  serial load word.
- write_addr  in  $clog2(MAX_LEN)  element index for the load.
- write_row  in  $clog2(NUM_ROWS)  row index for weight loads.
- write_en_w  in  1  writes data_in to W[write_row][write_addr].
- write_en_x  in  1  writes data_in to x[write_addr].
- start_calc  in  1  single-cycle request; sampled only in IDLE.
- vector_length  in  $clog2(MAX_LEN+1)  active length L, sampled with start_calc.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  a result beat is presented.
- result_ready  in  1  consumer accepts the beat when it is high together with result_valid.
- result_row  out  $clog2(NUM_ROWS)  row index of the current beat.
- result  out  DATA_WIDTH  rounded, saturated dot product of that row.
- calc_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE → MAC → ROUND → OUTPUT → IDLE.
- IDLE:
  - Writes take effect on the clock edge.
  - When start_calc is high, L is latched and clamped to MAX_LEN if larger, all accumulators are cleared, and the element counter k is set to 0.
  - L=0 goes directly to ROUND with zero sums.
- MAC: each cycle, acc[r] += W[r][k]·x[k] for every r, and k increments. After the cycle with k=L-1, the FSM goes to ROUND.
- ROUND (1 cycle):
  - Compute y[r] = (acc[r] + 2^(FRAC_BITS-1)) >>> FRAC_BITS. This is round-half-up; with FRAC_BITS=0 no rounding constant is added.
  - Saturate y[r] to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and register it into an output buffer.
- OUTPUT:
  - Rows are presented in order 0..NUM_ROWS-1.
  - The presented beat advances on each valid&&ready.
  - Once row NUM_ROWS-1 is accepted, the FSM returns to IDLE and pulses calc_done.
- Widths: each product is 2·DATA_WIDTH signed. The accumulator is 2·DATA_WIDTH + $clog2(MAX_LEN) signed, so it never overflows internally.
- Writes while busy are ignored; W and x stay stable during a calculation.
- start_calc while busy is ignored; it is not queued.
- When write_en_w and write_en_x are both high, both writes occur.
- Reset clears the FSM, counters, result_valid and calc_done. It does not clear the W and x RAMs; their contents are undefined after power-up.

## Timing
- Reset values: busy=0, result_valid=0, result_row=0, result=0, calc_done=0.
- busy rises the cycle after start_calc is accepted.
- The first result_valid appears L+2 cycles after the start edge (L MAC cycles + ROUND). For L=0 it appears 2 cycles after.
- With result_ready held high, one beat is transferred per cycle and calc_done pulses 1 cycle after the last accept.
- Under backpressure, result and result_row hold while valid is high and ready is low. Valid never drops without an accept.
- Reset asserted mid-calculation or mid-output: the next edge returns to IDLE with valid=0, and no calc_done is produced.
- A start_calc in the cycle calc_done is pulsed is accepted (the FSM is already in IDLE).

## Configuration
- DOT_PRODUCT_ARRAY_BIAS_EN defined:
  - Adds a per-row bias RAM B[NUM_ROWS], written with write_en_b (1-bit input) at write_row.
  - In IDLE, acc[r] is initialised to B[r] sign-extended and shifted left by FRAC_BITS instead of 0.
  - With L=0, the result equals B[r] after saturation.
- Undefined: no write_en_b port, no bias storage, accumulators start at 0.

## Structure
- Shared package dot_product_pkg holds:
  - The FSM state encoding (S_IDLE, S_MAC, S_ROUND, S_OUTPUT).
  - An accumulator-width function of DATA_WIDTH and MAX_LEN.
  - The round-and-saturate function.
- One sub-module, mac_lane: a single-row signed multiply-accumulate with clear, enable and accumulator output. It is instantiated NUM_ROWS times via generate.

## Test plan
All scenarios use defaults (DW=16, FRAC=8).
- Row 0 W=[0x0100,0x0200,0x0300], x=[0x0100,0x0100,0x0100], L=3, ready=1 → row 0 result=0x0600, first valid 5 cycles after start, calc_done after 4 beats.
- All rows W=0x7F00, x=0x7F00, L=4 → every result=0x7FFF. With W=0x8100 on the same x → 0x8000.
- Rounding: W=0x0001, x=0x0080, L=1 → 0x0001. W=0x0001, x=0x007F → 0x0000.
- L=0, then L=20 (clamped to 16, all ones in Q8.8) → results 0x0000, then 0x1000.
- ready toggled 1010… during OUTPUT → result and result_row stable while stalled, all 4 rows delivered in order, exactly one calc_done pulse.
- rstn low for 1 cycle during MAC with L=16 → busy=0 and valid=0 next cycle. A new start with the RAMs unchanged gives the correct result. Writes and start while busy are ignored.
